uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised successor UART transmitter.
- Adds a runtime baud divisor, runtime parity and stop-bit selection, a valid/ready input handshake, and back-to-back framing with no idle gap.
- An input FIFO can be compiled in.
- Sits between the bus-side register block and the serial pin, feeding one tx line.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
- DIV_W, 16, width of the baud divisor input.
- FIFO_DEPTH, 8, entries in the input FIFO; power of two ≥2; used only with UART_TX_FIFO_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- baud_div  in  DIV_W  clocks per bit; 0 is treated as 1
- parity_mode  in  2  0 none, 1 odd, 2 even, 3 none
- two_stop  in  1  0 = one stop bit, 1 = two stop bits
- tx_data  in  DATA_WIDTH  payload, LSB transmitted first
- tx_valid  in  1  payload present
- tx_ready  out  1  block can accept payload this cycle
- tx  out  1  serial line, idle high
- tx_busy  out  1  a frame is in progress
- tx_done  out  1  one-cycle pulse at end of each frame
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the frame in flight

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - Outputs: tx=1, tx_busy=0, tx_done=0, tx_ready=0 during reset, 1 from the first cycle after reset, fifo_count=0.
  - Internals: state=IDLE, all counters 0, holding register/FIFO flushed.
  - Reset mid-frame aborts the frame; tx returns high the cycle after.
- Handshake:
  - Transfer occurs when tx_valid && tx_ready at a clk edge.
  - tx_data is sampled only on a transfer.
  - tx_valid may be held without a transfer; there is no combinational path from tx_valid to tx_ready.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If an entry is queued, pop it into the shift register.
  - Latch baud_div (0→1), parity_mode and two_stop for the whole frame.
  - Compute parity from the popped data: even → ^data, odd → ~^data.
  - Go to START next cycle.
- Frame bits and timing:
  - Each bit holds tx for exactly B = latched baud_div clocks.
  - A baud counter counts 0..B-1; the state advances when it reaches B-1.
  - START: tx=0.
  - DATA: DATA_WIDTH bits LSB first; bit counter 0..DATA_WIDTH-1.
  - PARITY: present only if the latched mode is 1 or 2.
  - STOP: tx=1 for 1 or 2 bit periods.
- Frame end:
  - On the last clock of the final stop bit, tx_done is asserted for the next cycle.
  - In that same cycle, if an entry is queued, the next frame's START begins (tx=0). Otherwise the block goes to IDLE.
  - Result: back-to-back frames have zero idle clocks between stop and start.
- Latency:
  - Transfer at edge N into an empty, idle block: the IDLE pop happens in cycle N+1, and tx falls at edge N+2.
  - Frame length = B × (1 + DATA_WIDTH + P + S) clocks.
- tx_busy: high from the first START clock through the last STOP clock.
- Config inputs changing mid-frame have no effect until the next frame.
- Without FIFO:
  - Single holding register.
  - tx_ready = !holding_full.
  - A second payload can be accepted during a frame.
  - fifo_count ∈ {0,1}.
- Simultaneous load and pop of the holding register is permitted: the register holds the new data and stays full.

Optional Feature:
- Macro: UART_TX_FIFO_EN.
- Defined:
  - The holding register is replaced by a FIFO_DEPTH circular FIFO with wrapping read/write pointers.
  - tx_ready = !full.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - When full, tx_ready=0, so no push occurs even if a pop occurs that cycle.
  - Pop from empty never occurs.
  - fifo_count is 0..FIFO_DEPTH.
- Undefined: single holding register as above; FIFO_DEPTH is ignored.

Decomposition:
- Shared package gets:
  - uart_tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - uart_parity_e {PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2, PAR_NONE2=3}.
  - A parity function taking data and mode.
- Sub-module uart_baud_gen:
  - Loadable down-counter that emits a bit_end strobe every B clocks.
  - Restarted at each frame start.

Test Plan:
- Basic even-parity frame:
  - Stimulus: baud_div=4, parity_mode=2, two_stop=0, send 0xA5.
  - Required: tx = 0,1,0,1,0,0,1,0,1,0,1, each held 4 clocks (44 clocks total); tx_done pulses once, the cycle after the final stop bit.
- Odd parity, two stop bits:
  - Stimulus: parity_mode=1, two_stop=1, send 0xA5.
  - Required: parity bit=1; stop held 8 clocks; frame 48 clocks.
- Zero divisor, no parity, back-to-back:
  - Stimulus: baud_div=0, parity_mode=0, tx_valid held with 0x00 then 0xFF.
  - Required: 1 clock per bit; second start bit immediately follows the first stop bit (zero gap); two tx_done pulses 10 clocks apart.
- Full FIFO (UART_TX_FIFO_EN, FIFO_DEPTH=8):
  - Stimulus: push 9 words while tx is stalled by a slow baud.
  - Required: fifo_count reaches 8 and tx_ready=0; words emerge in push order; simultaneous push/pop keeps the count.
- Reset mid-frame:
  - Stimulus: assert rst mid-DATA.
  - Required: tx=1 and tx_busy=0 the next cycle; fifo_count=0; no tx_done.
- Config change mid-frame:
  - Stimulus: change baud_div and parity_mode mid-frame.
  - Required: current frame unaffected; next frame uses the new values.

Source files
------------

// File: rtl/uart_tx_frame_pkg.sv
// Shared types and parity helpers for the uart_tx_frame transmitter.
package uart_tx_frame_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_ODD   = 2'd1,
    PAR_EVEN  = 2'd2,
    PAR_NONE2 = 2'd3
  } uart_parity_e;

  localparam int MAX_DATA_W = 9;

  // Callers zero-extend narrower payloads; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data, input uart_parity_e mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic parity_en(input uart_parity_e mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_frame_baud_gen.sv
// Bit-period timer: strobes bit_end on the last clock of every B-clock bit period.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;

  // div is already clamped to >= 1; the period is held until the next restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= DIV_W'(1);
      cnt    <= '0;
    end else if (restart) begin
      period <= div;
      cnt    <= div - 1'b1;
    end else if (cnt == '0) begin
      cnt <= period - 1'b1;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with runtime divisor/parity/stop config and gap-free framing.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  logic                  push, pop, full, have_entry, rdy_en;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         count;

  // Ready comes from registers only, held low for the cycle after reset.
  always_ff @(posedge clk) rdy_en <= !rst;

  assign tx_ready   = rdy_en && !full;
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr, rptr;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign have_entry = (count != '0);
  assign head       = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= tx_data;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
`else
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;

  assign full       = hold_full;
  assign have_entry = hold_full;
  assign head       = hold;
  assign count      = CW'(hold_full);

  // A load in the same cycle as a pop wins: the register stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end
`endif

  uart_tx_state_e        state, state_nx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt, par_on, par_val, two_l;
  logic                  bit_end, frame_end, tx_nx, done_d;
  logic [DIV_W-1:0]      div_eff;
  uart_parity_e          pmode;

  assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign pmode   = uart_parity_e'(parity_mode);

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (pop),
    .div     (div_eff),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    frame_end = 1'b0;
    tx_nx     = 1'b1;
    case (state)
      IDLE: if (have_entry) begin
        pop      = 1'b1;
        state_nx = START;
      end
      START: begin
        tx_nx = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx_nx = shreg[0];
        if (bit_end && bit_cnt == BW'(DATA_WIDTH-1)) state_nx = par_on ? PARITY : STOP;
      end
      PARITY: begin
        tx_nx = par_val;
        if (bit_end) state_nx = STOP;
      end
      STOP: if (bit_end && (!two_l || stop_cnt)) begin
        // Last stop clock: chain straight into the next START when data waits.
        frame_end = 1'b1;
        if (have_entry) begin
          pop      = 1'b1;
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_on   <= 1'b0;
      par_val  <= 1'b0;
      two_l    <= 1'b0;
    end else if (pop) begin
      shreg    <= head;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_on   <= parity_en(pmode);
      par_val  <= parity_bit(MAX_DATA_W'(head), pmode);
      two_l    <= two_stop;
    end else if (bit_end) begin
      if (state == DATA) begin
        shreg   <= shreg >> 1;
        bit_cnt <= (bit_cnt == BW'(DATA_WIDTH-1)) ? '0 : bit_cnt + 1'b1;
      end
      if (state == STOP) stop_cnt <= !stop_cnt;
    end
  end

  // Registered outputs; tx_done trails the last tx stop clock by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      done_d  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx      <= tx_nx;
      tx_busy <= (state != IDLE);
      done_d  <= frame_end;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus a random traffic
// run scored against a frame-level timeline model built from logged inputs.
module tb_uart_tx_frame;

  localparam int LOGN = 16384;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, tx_busy, tx_done;
  logic [3:0]  fifo_count;

  int errors = 0, checks = 0, cyc = 0;

  logic        tx_l[LOGN], bsy_l[LOGN], dn_l[LOGN], rdy_l[LOGN], val_l[LOGN], ts_l[LOGN];
  logic [3:0]  cnt_l[LOGN];
  logic [7:0]  dat_l[LOGN];
  logic [15:0] bd_l[LOGN];
  logic [1:0]  pm_l[LOGN];
  logic        e_tx[LOGN], e_bsy[LOGN], e_dn[LOGN], e_rdy[LOGN];
  int          e_cnt[LOGN], delta[LOGN];

  uart_tx_frame dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index c holds outputs after edge c and the inputs that edge c sampled.
  always @(negedge clk) if (cyc < LOGN) begin
    tx_l[cyc]  <= tx;        bsy_l[cyc] <= tx_busy;  dn_l[cyc]  <= tx_done;
    rdy_l[cyc] <= tx_ready;  cnt_l[cyc] <= fifo_count;
    val_l[cyc] <= tx_valid;  dat_l[cyc] <= tx_data;  bd_l[cyc]  <= baud_div;
    pm_l[cyc]  <= parity_mode; ts_l[cyc] <= two_stop;
  end

  always @(posedge clk) if (cyc > LOGN - 4) begin
    $display("FAIL watchdog: cycle %0d exceeded budget %0d", cyc, LOGN - 4);
    $fatal(1, "cycle budget exhausted");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    tx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic reset_scn(input string tag, output int c0);
    tx_valid = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    c0 = cyc + 1;
    chk({tag, "_rst_tx"},    tx_l[cyc],  1);
    chk({tag, "_rst_busy"},  bsy_l[cyc], 0);
    chk({tag, "_rst_done"},  dn_l[cyc],  0);
    chk({tag, "_rst_ready"}, rdy_l[cyc], 0);
    chk({tag, "_rst_cnt"},   cnt_l[cyc], 0);
  endtask

  // Hold tx_valid with d until a transfer happens; e = transferring edge.
  task automatic send(input logic [7:0] d, output int e);
    int   guard;
    logic r;
    guard = 0;
    e = -1;
    tx_valid = 1'b1;
    tx_data  = d;
    while (e < 0 && guard < 5000) begin
      r = tx_ready;
      step();
      guard++;
      if (r === 1'b1) e = cyc;
    end
    checks++;
    assert (e >= 0) else begin
      errors++;
      $error("FAIL send_timeout: observed no transfer in %0d cycles expected a transfer", guard);
    end
  endtask

  // Timeline model: each accepted word starts its frame two clocks after
  // acceptance or right when the previous frame ends, whichever is later,
  // using the config present at the edge where it is popped.
  task automatic check_window(input int c0, input int c1, input string tag);
    int prev_end, s, b, p, l, k, cnt;
    int f_tx, f_bsy, f_dn, f_rdy, f_cnt;
    logic [7:0] d;
    logic par, bitv;
    for (int c = c0; c <= c1; c++) begin
      e_tx[c] = 1'b1; e_bsy[c] = 1'b0; e_dn[c] = 1'b0; delta[c] = 0;
    end
    prev_end = 0;
    for (int e = c0; e < c1; e++) begin
      if (val_l[e] === 1'b1 && rdy_l[e-1] === 1'b1) begin
        s = (e + 2 > prev_end) ? e + 2 : prev_end;
        b = (bd_l[s-1] == 16'd0) ? 1 : int'(bd_l[s-1]);
        p = (pm_l[s-1] == 2'd1 || pm_l[s-1] == 2'd2) ? 1 : 0;
        l = b * (10 + p + int'(ts_l[s-1]));
        d = dat_l[e];
        par = (pm_l[s-1] == 2'd2) ? ^d : ~^d;
        for (int j = 0; j < l; j++) begin
          k = j / b;
          if (k == 0)                bitv = 1'b0;
          else if (k <= 8)           bitv = d[k-1];
          else if (p == 1 && k == 9) bitv = par;
          else                       bitv = 1'b1;
          if (s + j < LOGN) begin e_tx[s+j] = bitv; e_bsy[s+j] = 1'b1; end
        end
        if (s + l < LOGN) e_dn[s+l] = 1'b1;
        prev_end = s + l;
        delta[e]++;
        delta[s-1]--;
      end
    end
    cnt = 0;
    for (int c = c0; c < c1; c++) begin
      cnt += delta[c];
      e_cnt[c] = cnt;
      e_rdy[c] = (cnt < CAP);
    end
    f_tx = c0; f_bsy = c0; f_dn = c0; f_rdy = c0; f_cnt = c0;
    for (int c = c1 - 1; c >= c0; c--) begin
      if (tx_l[c]  !== e_tx[c])  f_tx  = c;
      if (bsy_l[c] !== e_bsy[c]) f_bsy = c;
      if (dn_l[c]  !== e_dn[c])  f_dn  = c;
      if (rdy_l[c] !== e_rdy[c]) f_rdy = c;
      if (int'(cnt_l[c]) != e_cnt[c] || $isunknown(cnt_l[c])) f_cnt = c;
    end
    chk($sformatf("%s_tx@%0d",    tag, f_tx),  tx_l[f_tx],   e_tx[f_tx]);
    chk($sformatf("%s_busy@%0d",  tag, f_bsy), bsy_l[f_bsy], e_bsy[f_bsy]);
    chk($sformatf("%s_done@%0d",  tag, f_dn),  dn_l[f_dn],   e_dn[f_dn]);
    chk($sformatf("%s_ready@%0d", tag, f_rdy), rdy_l[f_rdy], e_rdy[f_rdy]);
    chk($sformatf("%s_count@%0d", tag, f_cnt), cnt_l[f_cnt], e_cnt[f_cnt]);
  endtask

  initial begin
    int c0, e, e2, s, s2, r, n, mx, fi;
    int dq[$];
    logic [10:0] pat;

    // Even parity, B=4, 0xA5
    reset_scn("s1", c0);
    baud_div = 16'd4; parity_mode = 2'd2; two_stop = 1'b0;
    step();
    chk("s1_ready_after_rst", rdy_l[c0], 1);
    send(8'hA5, e);
    idle(60);
    s = e + 2;
    chk("s1_lat_hi", tx_l[e+1], 1);
    chk("s1_lat_lo", tx_l[s], 0);
    pat = 11'b10101001010;
    for (int i = 0; i < 11; i++) chk($sformatf("s1_bit%0d", i), tx_l[s + 4*i + 2], pat[i]);
    chk("s1_done_at_44", dn_l[s+44], 1);
    chk("s1_no_done_43", dn_l[s+43], 0);
    check_window(c0, cyc, "s1");

    // Odd parity, two stop bits
    reset_scn("s2", c0);
    baud_div = 16'd4; parity_mode = 2'd1; two_stop = 1'b1;
    step();
    send(8'hA5, e);
    idle(70);
    s = e + 2;
    chk("s2_parity", tx_l[s + 36 + 2], 1);
    n = 0;
    for (int i = 40; i < 48; i++) n += (tx_l[s+i] === 1'b1) ? 1 : 0;
    chk("s2_stop_len", n, 8);
    chk("s2_done_at_48", dn_l[s+48], 1);
    chk("s2_no_done_47", dn_l[s+47], 0);
    check_window(c0, cyc, "s2");

    // Divisor 0, no parity, back-to-back
    reset_scn("s3", c0);
    baud_div = 16'd0; parity_mode = 2'd0; two_stop = 1'b0;
    step();
    send(8'h00, e);
    send(8'hFF, e2);
    idle(30);
    s = e + 2;
    chk("s3_stop1", tx_l[s+9], 1);
    chk("s3_start2_nogap", tx_l[s+10], 0);
    dq.delete();
    for (int c = e; c < cyc; c++) if (dn_l[c] === 1'b1) dq.push_back(c);
    chk("s3_done_cnt", dq.size(), 2);
    chk("s3_done1_at", (dq.size() > 0) ? dq[0] : -1, s + 10);
    chk("s3_done_gap", (dq.size() > 1) ? dq[1] - dq[0] : -1, 10);
    check_window(c0, cyc, "s3");

    // Config change mid-frame
    reset_scn("s4", c0);
    baud_div = 16'd3; parity_mode = 2'd2; two_stop = 1'b0;
    step();
    send(8'h5A, e);
    s = e + 2;
    idle(s + 10 - cyc);
    baud_div = 16'd5; parity_mode = 2'd1; two_stop = 1'b1;
    idle(s + 35 - cyc);
    send(8'h5A, e2);
    idle(80);
    s2 = e2 + 2;
    chk("s4_f1_parity", tx_l[s + 27 + 1], 0);
    chk("s4_f1_done", dn_l[s+33], 1);
    chk("s4_f2_parity", tx_l[s2 + 45 + 2], 1);
    chk("s4_f2_done", dn_l[s2+60], 1);
    check_window(c0, cyc, "s4");

    // Fill the queue behind a slow baud
    reset_scn("s5", c0);
    baud_div = 16'd12; parity_mode = 2'd0; two_stop = 1'b0;
    step();
    for (int i = 0; i <= CAP; i++) send(8'h10 + 8'(i), e);
    idle((CAP + 1) * 120 + 40);
    mx = 0; fi = c0;
    for (int c = cyc - 1; c >= c0; c--) begin
      if (int'(cnt_l[c]) > mx) mx = int'(cnt_l[c]);
      if (int'(cnt_l[c]) == CAP) fi = c;
    end
    chk("s5_max_count", mx, CAP);
    chk("s5_full_not_ready", rdy_l[fi], 0);
    check_window(c0, cyc, "s5");

    // Random traffic and config
    reset_scn("s6", c0);
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        baud_div    = 16'($urandom_range(0, 4));
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
      n = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      if (n > 0) idle(n);
      send(8'($urandom), e);
    end
    idle(500);
    check_window(c0, cyc, "s6");

    // Reset mid-DATA with a second word queued
    reset_scn("s7", c0);
    baud_div = 16'd4; parity_mode = 2'd2; two_stop = 1'b0;
    step();
    send(8'h3C, e);
    send(8'hC3, e2);
    s = e + 2;
    idle(s + 15 - cyc);
    rst = 1'b1;
    step();
    r = cyc;
    rst = 1'b0;
    idle(80);
    chk("s7_pre_busy", bsy_l[r-1], 1);
    chk("s7_pre_cnt", cnt_l[r-1], 1);
    chk("s7_tx", tx_l[r], 1);
    chk("s7_busy", bsy_l[r], 0);
    chk("s7_cnt", cnt_l[r], 0);
    chk("s7_ready_in_rst", rdy_l[r], 0);
    chk("s7_ready_after", rdy_l[r+1], 1);
    n = 0; mx = 0;
    for (int c = r; c < cyc; c++) begin
      n  += (dn_l[c] !== 1'b0) ? 1 : 0;
      mx += (tx_l[c] !== 1'b1) ? 1 : 0;
    end
    chk("s7_no_done", n, 0);
    chk("s7_tx_stays_high", mx, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
